// File: rtl/cpu_control_unit.sv
// Control FSM for the accumulator datapath: start, fetch, decode and execute sequencing,
// datapath strobes, operator Enter handshake and a retired-instruction counter.
module cpu_control_unit #(
    parameter int RESET_CYCLES = 1,
    parameter int CNT_W        = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [2:0]       IR,
    input  logic             Aeq0,
    input  logic             Apos,
    input  logic             Enter,
    output logic             DPReset,
    output logic             IRload,
    output logic             PCload,
    output logic             JMPmux,
    output logic             Meminst,
    output logic             MemWr,
    output logic [1:0]       Asel,
    output logic             Aload,
    output logic             Sub,
    output logic             Halt,
    output logic [CNT_W-1:0] InstrCount
);

    localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RESET_CYCLES - 1);

    typedef enum logic [3:0] {
        ST_START,
        ST_FETCH,
        ST_DECODE,
        ST_LOAD,
        ST_STORE,
        ST_ADD,
        ST_SUB,
        ST_INWAIT,
        ST_INLOAD,
        ST_JZ,
        ST_JPOS,
        ST_HALT
    } state_t;

    typedef struct packed {
        logic       dp_reset;
        logic       ir_load;
        logic       pc_load;
        logic       jmp_mux;
        logic       mem_inst;
        logic       mem_wr;
        logic [1:0] asel;
        logic       a_load;
        logic       sub;
        logic       halt;
    } ctrl_t;

    state_t           r_state;
    state_t           w_next;
    ctrl_t            r_ctrl;
    logic [RC_W-1:0]  r_rst_cnt;
    logic [CNT_W-1:0] r_count;
    logic             r_enter_q;
    logic             w_enter_edge;
    logic             w_in_jz;
    logic             w_in_jpos;

    // Strobe pattern for a state; the conditional jump strobes are added combinationally below.
    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            ST_START:  c.dp_reset = 1'b1;
            ST_FETCH: begin
                c.ir_load = 1'b1;
                c.pc_load = 1'b1;
            end
            ST_DECODE: c.mem_inst = 1'b1;
            ST_LOAD: begin
                c.asel   = 2'b10;
                c.a_load = 1'b1;
            end
            ST_STORE: begin
                c.mem_inst = 1'b1;
                c.mem_wr   = 1'b1;
            end
            ST_ADD:    c.a_load = 1'b1;
            ST_SUB: begin
                c.a_load = 1'b1;
                c.sub    = 1'b1;
            end
            ST_INLOAD: begin
                c.asel   = 2'b01;
                c.a_load = 1'b1;
            end
            ST_HALT:   c.halt = 1'b1;
            default:   c = '0;
        endcase
        return c;
    endfunction

    assign w_enter_edge = Enter & ~r_enter_q;

    // NOTE: every variable assigned here gets a default first so no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_START:  if (r_rst_cnt == RC_LAST) w_next = ST_FETCH;
            ST_FETCH:  w_next = ST_DECODE;
            ST_DECODE: begin
                case (IR)
                    3'b000:  w_next = ST_LOAD;
                    3'b001:  w_next = ST_STORE;
                    3'b010:  w_next = ST_ADD;
                    3'b011:  w_next = ST_SUB;
                    3'b100:  w_next = ST_INWAIT;
                    3'b101:  w_next = ST_JZ;
                    3'b110:  w_next = ST_JPOS;
                    default: w_next = ST_HALT;
                endcase
            end
            ST_LOAD, ST_STORE, ST_ADD, ST_SUB,
            ST_INLOAD, ST_JZ, ST_JPOS: w_next = ST_FETCH;
            ST_INWAIT: if (w_enter_edge) w_next = ST_INLOAD;
            ST_HALT:   w_next = ST_HALT;
            default:   w_next = ST_START;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    // Strobes are registered from the next state, so they line up with the state register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state   <= ST_START;
            r_ctrl    <= decode_ctrl(ST_START);
            r_rst_cnt <= '0;
            r_count   <= '0;
            r_enter_q <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_ctrl    <= decode_ctrl(w_next);
            r_enter_q <= Enter;
            if (r_state == ST_START) r_rst_cnt <= r_rst_cnt + RC_W'(1);
            else                     r_rst_cnt <= '0;
            if (r_state == ST_DECODE) r_count <= r_count + CNT_W'(1);
        end
    end

    assign w_in_jz   = (r_state == ST_JZ);
    assign w_in_jpos = (r_state == ST_JPOS);

    assign DPReset    = r_ctrl.dp_reset;
    assign IRload     = r_ctrl.ir_load;
    assign PCload     = r_ctrl.pc_load | (w_in_jz & Aeq0) | (w_in_jpos & Apos);
    assign JMPmux     = r_ctrl.jmp_mux | (w_in_jz & Aeq0) | (w_in_jpos & Apos);
    assign Meminst    = r_ctrl.mem_inst;
    assign MemWr      = r_ctrl.mem_wr;
    assign Asel       = r_ctrl.asel;
    assign Aload      = r_ctrl.a_load;
    assign Sub        = r_ctrl.sub;
    assign Halt       = r_ctrl.halt;
    assign InstrCount = r_count;

endmodule
